shift_frame_ctrl: RTL and testbench

//   Sequencer for the serial shift path. Accepts a parallel word over a

---
 rtl/shift_frame_pkg.sv | 26 ++
 rtl/shift_frame_ctrl_piso.sv | 28 ++
 rtl/shift_frame_ctrl.sv | 144 ++++++++++++++
 tb/tb_shift_frame_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/shift_frame_pkg.sv
// Shared types and helpers for the serial frame sequencer.
// FSM state enum, counter-width and frame-length helpers.
package shift_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PAR,
    ST_GAP
  } state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic int frame_len(input int w);
`ifdef SHIFT_FRAME_PARITY_EN
    return w + 1;
`else
    return w;
`endif
  endfunction

  localparam int CNT_W_DEF = cnt_w(4);

endpackage

// File: rtl/shift_frame_ctrl_piso.sv
// Parallel-load, shift-left register; MSB is the serial bit.
// Ports: clk/rst, load_i/shift_i enables, data_i word, msb_o.
module piso_shifter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= data_i;
    end else if (shift_i) begin
      sr_q <= {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb_o = sr_q[WIDTH-1];

endmodule

// File: rtl/shift_frame_ctrl.sv
// Word-to-serial frame sequencer: valid/ready in, MSB-first bits out,
// ser_en strobe, busy, done pulse, GAP idle cycles between frames.
// Ports: clk, rst, in_data/in_valid/in_ready, ser_out, ser_en, busy, done.
// Option: SHIFT_FRAME_PARITY_EN appends an even-parity bit to each frame.
module shift_frame_ctrl
  import shift_frame_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_en,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam int GW    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int GLD   = (GAP > 0) ? GAP - 1 : 0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             done_q, done_d;
  logic             load, shift, msb, frame_end;
`ifdef SHIFT_FRAME_PARITY_EN
  logic             par_q, par_d;
`endif

  piso_shifter #(.WIDTH(WIDTH)) u_piso (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .shift_i(shift),
    .data_i (in_data),
    .msb_o  (msb)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    done_d    = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    frame_end = 1'b0;
    in_ready  = 1'b0;
    ser_en    = 1'b0;
    ser_out   = 1'b0;
`ifdef SHIFT_FRAME_PARITY_EN
    par_d     = par_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          cnt_d   = CNT_W'(WIDTH - 1);
          state_d = ST_SHIFT;
`ifdef SHIFT_FRAME_PARITY_EN
          par_d   = ^in_data;
`endif
        end
      end
      ST_SHIFT: begin
        ser_en  = 1'b1;
        ser_out = msb;
        shift   = 1'b1;
        if (cnt_q == '0) begin
`ifdef SHIFT_FRAME_PARITY_EN
          state_d = ST_PAR;
`else
          frame_end = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef SHIFT_FRAME_PARITY_EN
      ST_PAR: begin
        ser_en    = 1'b1;
        ser_out   = par_q;
        frame_end = 1'b1;
      end
`endif
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Last frame bit: with no gap a new word may load here so the
    // next frame follows without a dead cycle.
    if (frame_end) begin
      done_d = 1'b1;
      if (GAP == 0) begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          cnt_d   = CNT_W'(WIDTH - 1);
          state_d = ST_SHIFT;
`ifdef SHIFT_FRAME_PARITY_EN
          par_d   = ^in_data;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        state_d = ST_GAP;
        gap_d   = GW'(GLD);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
`ifdef SHIFT_FRAME_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
`ifdef SHIFT_FRAME_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Directed bench for shift_frame_ctrl: GAP=1 and GAP=0 instances.
// Parity expectations follow SHIFT_FRAME_PARITY_EN.
module tb_shift_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a_data, b_data;
  logic       a_valid, b_valid;
  logic       a_rdy, a_out, a_en, a_busy, a_done;
  logic       b_rdy, b_out, b_en, b_busy, b_done;

  int errors = 0;
  int checks = 0;
  bit eq[$];

  always #5 clk = ~clk;

  shift_frame_ctrl #(.WIDTH(4), .GAP(1)) u_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_rdy), .ser_out(a_out), .ser_en(a_en),
    .busy(a_busy), .done(a_done)
  );

  shift_frame_ctrl #(.WIDTH(4), .GAP(0)) u_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_rdy), .ser_out(b_out), .ser_en(b_en),
    .busy(b_busy), .done(b_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic add_frame(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) eq.push_back(w[i]);
`ifdef SHIFT_FRAME_PARITY_EN
    eq.push_back(^w);
`endif
  endtask

  initial begin
    rst = 1'b1;
    a_data = '0; a_valid = 1'b0;
    b_data = '0; b_valid = 1'b0;

    // 1: reset
    repeat (3) step();
    rst = 1'b0;
    chk("rst_en", a_en, 1'b0);
    chk("rst_out", a_out, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_rdy", a_rdy, 1'b1);
    chk("rst_b_rdy", b_rdy, 1'b1);

    // 2: single frame 1011, GAP=1
    a_data = 4'b1011; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    eq.delete(); add_frame(4'b1011);
    foreach (eq[i]) begin
      chk("s2_en", a_en, 1'b1);
      chk("s2_bit", a_out, eq[i]);
      chk("s2_nodone", a_done, 1'b0);
      chk("s2_rdy", a_rdy, 1'b0);
      step();
    end
    chk("s2_done", a_done, 1'b1);
    chk("s2_gap_en", a_en, 1'b0);
    chk("s2_gap_out", a_out, 1'b0);
    chk("s2_gap_busy", a_busy, 1'b1);
    chk("s2_gap_rdy", a_rdy, 1'b0);
    step();
    chk("s2_idle_rdy", a_rdy, 1'b1);
    chk("s2_idle_done", a_done, 1'b0);
    chk("s2_idle_busy", a_busy, 1'b0);

    // 4: word held during busy frame is not taken until after GAP
    a_data = 4'b1111; a_valid = 1'b1;
    step();
    a_data = 4'b0001;
    eq.delete(); add_frame(4'b1111);
    foreach (eq[i]) begin
      chk("s4_rdy", a_rdy, 1'b0);
      chk("s4_bit", a_out, eq[i]);
      step();
    end
    chk("s4_done", a_done, 1'b1);
    chk("s4_gap_rdy", a_rdy, 1'b0);
    step();
    chk("s4_idle_rdy", a_rdy, 1'b1);
    chk("s4_idle_en", a_en, 1'b0);
    step();
    a_valid = 1'b0;
    eq.delete(); add_frame(4'b0001);
    foreach (eq[i]) begin
      chk("s4b_en", a_en, 1'b1);
      chk("s4b_bit", a_out, eq[i]);
      step();
    end
    chk("s4b_done", a_done, 1'b1);
    step();
    chk("s4b_idle", a_busy, 1'b0);

    // 5: reset on the 2nd bit of 1010
    a_data = 4'b1010; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    chk("s5_bit0", a_out, 1'b1);
    step();
    chk("s5_bit1", a_out, 1'b0);
    chk("s5_bit1_en", a_en, 1'b1);
    rst = 1'b1; a_data = 4'b0101; a_valid = 1'b1;
    step();
    chk("s5_rst_en", a_en, 1'b0);
    chk("s5_rst_busy", a_busy, 1'b0);
    chk("s5_rst_done", a_done, 1'b0);
    step();
    chk("s5_rst2_busy", a_busy, 1'b0);
    chk("s5_rst2_done", a_done, 1'b0);
    rst = 1'b0;
    step();
    a_valid = 1'b0;
    eq.delete(); add_frame(4'b0101);
    foreach (eq[i]) begin
      chk("s5_en", a_en, 1'b1);
      chk("s5_bit", a_out, eq[i]);
      step();
    end
    chk("s5_done", a_done, 1'b1);
    step();

    // 3: GAP=0 back-to-back frames with valid held
    b_data = 4'b1100; b_valid = 1'b1;
    step();
    b_data = 4'b0110;
    eq.delete(); add_frame(4'b1100); add_frame(4'b0110);
    foreach (eq[i]) begin
      chk("s3_en", b_en, 1'b1);
      chk("s3_bit", b_out, eq[i]);
      chk("s3_done", b_done, (i == eq.size() / 2));
      if (i == eq.size() / 2 - 1) chk("s3_rdy_last", b_rdy, 1'b1);
      if (i == 0) chk("s3_rdy_first", b_rdy, 1'b0);
      step();
      if (i == eq.size() / 2 - 1) b_valid = 1'b0;
    end
    chk("s3_done2", b_done, 1'b1);
    chk("s3_end_en", b_en, 1'b0);
    chk("s3_end_out", b_out, 1'b0);
    chk("s3_end_busy", b_busy, 1'b0);
    chk("s3_end_rdy", b_rdy, 1'b1);
    step();
    chk("s3_quiet", b_done, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
